// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Program-memory loader for the bit-serial CPU. Parses a framed
//             byte stream (HEADER, COUNT, COUNT x 3 word bytes, optional XOR
//             checksum), reassembles 18-bit instruction words and writes them
//             to consecutive program addresses from 0. Holds the CPU in reset
//             while a load is in progress.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous active-low reset
//             in_data    - stream byte
//             in_valid   - in_data valid
//             in_ready   - loader accepts a byte (transfer = valid & ready)
//             prog_addr  - program memory write address
//             prog_data  - instruction word {opc,rep,src1,src2,dest}
//             prog_we    - one-cycle write strobe
//             cpu_hold   - CPU reset request
//             done       - one-cycle pulse on successful frame end
//             err        - sticky frame error
//  Options  : PROG_LOADER_CHECKSUM_EN - frame ends with an XOR checksum byte
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int         WORDS         = 16,
    parameter int         ADDR_W        = 4,
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter logic       HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [17:0]       prog_data,
    output logic              prog_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int         c_rem_w     = $clog2(WORDS + 1);
    localparam logic [8:0] c_words_ext = 9'(WORDS);

    localparam logic [3:0] c_idle  = 4'd0;
    localparam logic [3:0] c_count = 4'd1;
    localparam logic [3:0] c_b0    = 4'd2;
    localparam logic [3:0] c_b1    = 4'd3;
    localparam logic [3:0] c_b2    = 4'd4;
    localparam logic [3:0] c_write = 4'd5;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [3:0] c_csum  = 4'd6;
`endif
    localparam logic [3:0] c_done  = 4'd7;
    localparam logic [3:0] c_err   = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_next_state;
    logic               w_ready;
    logic               w_hs;
    logic               w_start;
    logic [ADDR_W-1:0]  r_addr;
    logic [17:0]        r_data;
    logic [c_rem_w-1:0] r_rem;
    logic [1:0]         r_b0;
    logic [7:0]         r_b1;
    logic               r_hold;
    logic               r_err;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    // Ready is forced low while reset is asserted, whatever the old state.
    assign in_ready  = w_ready & reset;
    assign w_hs      = in_valid & in_ready;
    assign w_start   = w_hs && (in_data == HEADER) &&
                       ((r_state == c_idle) || (r_state == c_err));
    assign prog_addr = r_addr;
    assign prog_data = r_data;
    assign prog_we   = (r_state == c_write);
    assign done      = (r_state == c_done);
    assign cpu_hold  = r_hold;
    assign err       = r_err;

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            c_idle, c_err: begin
                w_ready = 1'b1;
                if (w_start) w_next_state = c_count;
            end
            c_count: begin
                w_ready = 1'b1;
                if (w_hs) begin
                    if ((in_data == 8'd0) || ({1'b0, in_data} > c_words_ext))
                        w_next_state = c_err;
                    else
                        w_next_state = c_b0;
                end
            end
            c_b0: begin
                w_ready = 1'b1;
                if (w_hs) w_next_state = (in_data[7:2] != 6'd0) ? c_err : c_b1;
            end
            c_b1: begin
                w_ready = 1'b1;
                if (w_hs) w_next_state = c_b2;
            end
            c_b2: begin
                w_ready = 1'b1;
                if (w_hs) w_next_state = c_write;
            end
            c_write: begin
                if (r_rem == c_rem_w'(1))
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next_state = c_csum;
`else
                    w_next_state = c_done;
`endif
                else
                    w_next_state = c_b0;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            c_csum: begin
                w_ready = 1'b1;
                if (w_hs) w_next_state = (in_data != r_csum) ? c_err : c_done;
            end
`endif
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_idle;
            r_addr  <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_hold  <= HOLD_AT_RESET;
            r_err   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_hold <= 1'b1;
                r_err  <= 1'b0;
                r_addr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_csum <= '0;
`endif
            end
            if (w_hs && (r_state == c_count)) r_rem <= c_rem_w'(in_data);
            if (w_hs && (r_state == c_b0))    r_b0  <= in_data[1:0];
            if (w_hs && (r_state == c_b1))    r_b1  <= in_data;
            // The word is committed to the output register only once complete,
            // so prog_data keeps the previous word until the next write.
            if (w_hs && (r_state == c_b2))    r_data <= {r_b0, r_b1, in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
            if (w_hs && ((r_state == c_b0) || (r_state == c_b1) || (r_state == c_b2)))
                r_csum <= r_csum ^ in_data;
`endif
            if (r_state == c_write) begin
                r_addr <= r_addr + 1'b1;
                r_rem  <= r_rem - 1'b1;
            end
            // Hold drops on the same edge that enters DONE.
            if ((w_next_state == c_done) && (r_state != c_done)) r_hold <= 1'b0;
            if ((w_next_state == c_err) && (r_state != c_err)) begin
                r_err  <= 1'b1;
                r_hold <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader. Frames are built from word
//             lists; expected writes, checksum and outcome are derived from
//             the frame format directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  prog_addr;
    logic [17:0] prog_data;
    logic        prog_we;
    logic        cpu_hold;
    logic        done;
    logic        err;

    prog_loader #(
        .WORDS(16), .ADDR_W(4), .HEADER(8'hA5), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_we(prog_we), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int r_cyc = 0;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed write / done events.
    logic [3:0]  wa_q[$];
    logic [17:0] wd_q[$];
    int          wc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (prog_we) begin
            wa_q.push_back(prog_addr);
            wd_q.push_back(prog_data);
            wc_q.push_back(r_cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = r_cyc;
            check_val("hold_at_done", {31'd0, cpu_hold}, 32'd0);
        end
    end

    // Stimulus state and reference data.
    logic [7:0]  stream[$];
    logic [17:0] exp_words[$];
    int          last_hs = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0;
    endtask

    // Frame from exp_words: header, count, big-endian 3-byte words, xor.
    task automatic make_stream();
        logic [7:0] x;
        x = 8'h00;
        stream.delete();
        stream.push_back(8'hA5);
        stream.push_back(8'(exp_words.size()));
        foreach (exp_words[i]) begin
            stream.push_back({6'd0, exp_words[i][17:16]});
            stream.push_back(exp_words[i][15:8]);
            stream.push_back(exp_words[i][7:0]);
            x = x ^ {6'd0, exp_words[i][17:16]} ^ exp_words[i][15:8] ^ exp_words[i][7:0];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            in_valid = 1'b0;
            for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check_val("ready_timeout", 32'd0, 32'd1);
        tick();
        last_hs  = r_cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes && i < stream.size(); i++) send_byte(stream[i], gaps);
    endtask

    task automatic check_good(input string tag, input bit full_rate);
        repeat (3) tick();
        check_val({tag, "_nwr"}, wa_q.size(), exp_words.size());
        foreach (exp_words[i]) begin
            if (i < wa_q.size()) begin
                check_val({tag, "_addr"}, {28'd0, wa_q[i]}, i);
                check_val({tag, "_data"}, {14'd0, wd_q[i]}, {14'd0, exp_words[i]});
                if (full_rate && i > 0) check_val({tag, "_gap"}, wc_q[i] - wc_q[i-1], 32'd4);
            end
        end
        check_val({tag, "_done"}, done_cnt, 32'd1);
        if (wc_q.size() > 0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            check_val({tag, "_done_t"}, done_cyc, last_hs);
`else
            check_val({tag, "_done_t"}, done_cyc, wc_q[wc_q.size()-1] + 1);
`endif
        end
        check_val({tag, "_err"}, {31'd0, err}, 32'd0);
        check_val({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic check_err(input string tag, input int nwr);
        repeat (3) tick();
        check_val({tag, "_err"}, {31'd0, err}, 32'd1);
        check_val({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        check_val({tag, "_nwr"}, wa_q.size(), nwr);
        check_val({tag, "_done"}, done_cnt, 32'd0);
        check_val({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic good_random_frame(input string tag, input int n, input bit gaps);
        clear_mon();
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back(18'($urandom));
        make_stream();
        send_stream(stream.size(), gaps);
        check_good(tag, !gaps);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog no finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] saved[$];
        // Reset state
        tick();
        check_val("rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("rst_addr", {28'd0, prog_addr}, 32'd0);
        check_val("rst_data", {14'd0, prog_data}, 32'd0);
        check_val("rst_we", {31'd0, prog_we}, 32'd0);
        check_val("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        tick();
        check_val("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Single word 0x01234 (checksum 0x26 when enabled)
        clear_mon();
        exp_words.delete();
        exp_words.push_back(18'h01234);
        make_stream();
        send_stream(stream.size(), 1'b0);
        check_good("one", 1'b1);

        // Full 16-word frame, i*0x1111
        clear_mon();
        exp_words.delete();
        for (int i = 0; i < 16; i++) exp_words.push_back(18'(i * 32'h1111));
        make_stream();
        send_stream(stream.size(), 1'b0);
        check_good("full", 1'b1);

        // Gapless vs gapped 3-word frame with identical words
        clear_mon();
        exp_words.delete();
        for (int i = 0; i < 3; i++) exp_words.push_back(18'($urandom));
        saved = exp_words;
        make_stream();
        send_stream(stream.size(), 1'b0);
        check_good("nogap", 1'b1);
        clear_mon();
        exp_words = saved;
        make_stream();
        send_stream(stream.size(), 1'b1);
        check_good("gap", 1'b0);

        // COUNT = 0
        clear_mon();
        stream = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34};
        send_stream(stream.size(), 1'b0);
        check_err("cnt0", 0);
        good_random_frame("rec0", 2, 1'b0);

        // COUNT = 17
        clear_mon();
        stream = '{8'hA5, 8'h11, 8'h00, 8'h12, 8'h34};
        send_stream(stream.size(), 1'b0);
        check_err("cnt17", 0);
        good_random_frame("rec17", 4, 1'b1);

        // B0 with a non-zero upper bit
        clear_mon();
        stream = '{8'hA5, 8'h01, 8'h04, 8'h12, 8'h34, 8'h26};
        send_stream(stream.size(), 1'b0);
        check_err("b0bad", 0);
        good_random_frame("recb0", 1, 1'b0);

        // Error on the second word: first write is kept
        clear_mon();
        stream = '{8'hA5, 8'h02, 8'h01, 8'hAB, 8'hCD, 8'hFC, 8'h00, 8'h00};
        send_stream(stream.size(), 1'b0);
        check_err("w2bad", 1);
        if (wd_q.size() > 0) check_val("w2bad_keep", {14'd0, wd_q[0]}, 32'h1ABCD);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum
        clear_mon();
        exp_words.delete();
        exp_words.push_back(18'h01234);
        make_stream();
        stream[stream.size()-1] = 8'h00;
        send_stream(stream.size(), 1'b0);
        check_err("csum", 1);
        good_random_frame("reccs", 3, 1'b0);
`endif

        // Random frames
        for (int k = 0; k < 4; k++)
            good_random_frame("rnd", $urandom_range(1, 16), k[0]);

        // Reset after B1 of the second word
        clear_mon();
        exp_words.delete();
        exp_words.push_back(18'($urandom));
        exp_words.push_back(18'($urandom));
        make_stream();
        send_stream(7, 1'b0);
        reset = 1'b0;
        #1;
        check_val("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("mid_rst_addr", {28'd0, prog_addr}, 32'd0);
        check_val("mid_rst_data", {14'd0, prog_data}, 32'd0);
        check_val("mid_rst_we", {31'd0, prog_we}, 32'd0);
        check_val("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("mid_rst_done", {31'd0, done}, 32'd0);
        check_val("mid_rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check_val("mid_rst_nwr", wa_q.size(), 32'd1);
        check_val("mid_rst_ndone", done_cnt, 32'd0);
        check_val("mid_rst_ready2", {31'd0, in_ready}, 32'd1);
        good_random_frame("after_rst", 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
